soi_event_capture: RTL and testbench
====================================

Name: soi_event_capture

Overview:
- Downstream consumer of a signal-of-interest (SOI) produced by a DUT-side observation point.
- Samples the SOI every clock and detects value changes. Each change is stored as a timestamped event in an internal FIFO.
- A reader (DPI-C export wrapper or on-chip drain logic) pops events over a valid/ready interface.
- Purpose: SOI activity is logged losslessly, or with counted drops, rather than polled.

Parameters:
- SOI_W, 1, width of observed signal
- TS_W, 32, timestamp counter width
- DEPTH, 16, FIFO entries (power of two, >=2)
- DROP_W, 16, width of saturating drop counter

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- soi  input  SOI_W  observed signal, synchronous to clk
- enable  input  1  capture enable
- evt_valid  output  1  head event available
- evt_ready  input  1  reader accepts head event
- evt_ts  output  TS_W  timestamp of head event
- evt_value  output  SOI_W  new SOI value of head event
- evt_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- drop_count  output  DROP_W  events lost to full FIFO, saturating

Behaviour:
- Interface decision: one clock, `clk`; reset `rst`, synchronous, active-high.
- Reset values:
  - evt_valid=0, evt_ts=0, evt_value=0, evt_count=0, drop_count=0.
  - Timestamp counter ts_q=0; armed=0; prev_q=0.
- Timestamp: ts_q increments by 1 every cycle after reset, independent of enable. It wraps from 2^TS_W-1 to 0 with no flag.
- Arming:
  - On the first rising edge where enable=1 and armed=0: prev_q<=soi, armed<=1, no event.
  - While enable=0: armed<=0. Re-enabling therefore re-arms without a spurious event.
- Change detect: at an edge where enable=1, armed=1 and soi!=prev_q:
  - Push {ts_q (pre-increment value), soi}.
  - prev_q<=soi.
  - prev_q updates even if the push is dropped.
- Latency: an event pushed at edge k makes evt_valid=1 after edge k (visible in cycle k+1). The FIFO is registered show-ahead.
- Pop: occurs at an edge where evt_valid=1 and evt_ready=1. evt_ready while evt_valid=0 is ignored.
- evt_ts/evt_value: stable while evt_valid=1 and not popped. Don't-care but held at their last value when evt_valid=0.
- Full:
  - A push is accepted if count<DEPTH, or if count==DEPTH and a pop occurs at the same edge.
  - Otherwise the push is discarded and drop_count increments, saturating at 2^DROP_W-1.
- Empty with simultaneous push: the event is not visible until the next cycle. There is no combinational bypass.
- Simultaneous push+pop: count unchanged; ordering preserved.
- evt_count: occupancy after the edge; range 0..DEPTH.
- Reset mid-operation: FIFO is flushed; drop_count, ts_q and armed are cleared; any in-flight event is lost.
- Occupancy tracking: pointers are log2(DEPTH) bits plus a wrap bit, so full and empty are distinguishable.

Decomposition:
- Package soi_obs_pkg:
  - Default parameter constants.
  - Parameterised typedef soi_evt_t {ts, value}, used by the FIFO payload and by the DPI wrapper.
- Sub-module soi_evt_fifo: synchronous show-ahead FIFO.
  - Signals: push/pop/din/dout/valid/count.
  - Full-with-pop accept rule.
- Top-level logic: timestamp counter, arming, change detect, drop counter.

Test Plan:
- Reset release, enable=1, soi held 0 for 10 cycles -> evt_valid stays 0, drop_count=0.
- Arm at ts=3, soi 0->1 sampled at ts=7 -> next cycle evt_valid=1, evt_ts=7, evt_value=1; after pop with evt_ready=1, evt_count=0.
- Toggle soi every cycle for 20 changes with evt_ready=0, DEPTH=16 -> evt_count=16, drop_count=4.
  - Then drain -> 16 events with consecutive timestamps, values alternating.
- FIFO full with evt_ready=1 while soi toggles -> every edge pops and pushes, count stays 16, drop_count unchanged.
- Enable low, soi changed 0->1, enable high -> no event on re-arm; the next change 1->0 yields evt_value=0.
- Assert rst for 1 cycle with 5 queued events and drop_count=2 -> after the edge, evt_valid=0, evt_count=0, drop_count=0, ts restarts at 0.
- TS_W=4 override, change at ts=15 then 2 cycles later -> evt_ts=15 then 1 (wrap).

Source files
------------

// File: rtl/soi_obs_pkg.sv
// Shared constants and event record type for the SOI observation/capture path.
package soi_obs_pkg;

    localparam int SOI_W_DEF  = 1;
    localparam int TS_W_DEF   = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int DROP_W_DEF = 16;

    // Default-width event record; modules with overridden widths build their own.
    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [SOI_W_DEF-1:0] value;
    } soi_evt_t;

endpackage

// File: rtl/soi_evt_fifo.sv
// Synchronous show-ahead FIFO: head entry is held in a register, so dout is
// valid the cycle after the push that made it the head.
module soi_evt_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_reg, rd_reg;
    logic [AW:0]   wr_next, rd_next, count_next;
    logic [W-1:0]  dout_reg;
    logic          full, pop_ok, push_ok;
    logic          load_head, head_from_din;
    logic [AW-1:0] head_idx;

    always_comb begin
        count      = wr_reg - rd_reg;
        valid      = (count != '0);
        full       = (count == (AW+1)'(DEPTH));
        pop_ok     = pop && valid;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok    = push && (!full || pop_ok);
        drop       = push && !push_ok;
        wr_next    = wr_reg + (AW+1)'(push_ok);
        rd_next    = rd_reg + (AW+1)'(pop_ok);
        count_next = wr_next - rd_next;
        head_idx   = rd_next[AW-1:0];
        load_head  = (count_next != '0) && (pop_ok || !valid);
        // The new head is the word being written this edge only when it lands at head_idx.
        head_from_din = push_ok && (head_idx == wr_reg[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_reg   <= '0;
            rd_reg   <= '0;
            dout_reg <= '0;
        end else begin
            wr_reg <= wr_next;
            rd_reg <= rd_next;
            if (load_head) begin
                dout_reg <= head_from_din ? din : mem[head_idx];
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/soi_event_capture.sv
// Samples an observed signal each clock and queues every value change with
// its timestamp; events that find the queue full are counted instead.
module soi_event_capture
    import soi_obs_pkg::*;
#(
    parameter int SOI_W  = SOI_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SOI_W-1:0]         soi,
    input  logic                     enable,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [SOI_W-1:0]         evt_value,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic [DROP_W-1:0]        drop_count
);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [SOI_W-1:0] value;
    } evt_t;

    logic [TS_W-1:0]   ts_reg;
    logic [SOI_W-1:0]  prev_reg;
    logic              armed_reg;
    logic [DROP_W-1:0] drop_reg;
    logic              change, fifo_drop;
    evt_t              push_evt, head_evt;

    assign change   = enable && armed_reg && (soi != prev_reg);
    assign push_evt = '{ts: ts_reg, value: soi};

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg    <= '0;
            prev_reg  <= '0;
            armed_reg <= 1'b0;
            drop_reg  <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
            // Arming snapshots the current value so enabling never emits an event.
            if (!enable) begin
                armed_reg <= 1'b0;
            end else if (!armed_reg || change) begin
                armed_reg <= 1'b1;
                prev_reg  <= soi;
            end
            if (fifo_drop && !(&drop_reg)) begin
                drop_reg <= drop_reg + DROP_W'(1);
            end
        end
    end

    soi_evt_fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .pop   (evt_ready),
        .din   (push_evt),
        .dout  (head_evt),
        .valid (evt_valid),
        .count (evt_count),
        .drop  (fifo_drop)
    );

    assign evt_ts     = head_evt.ts;
    assign evt_value  = head_evt.value;
    assign drop_count = drop_reg;

endmodule

// File: tb/tb_soi_event_capture.sv
// Directed bench for soi_event_capture: default instance plus a TS_W=4 instance for wrap.
module tb_soi_event_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  soi = 1'b0;
    logic        enable = 1'b0;
    logic        evt_ready = 1'b0;
    logic        evt_valid;
    logic [31:0] evt_ts;
    logic [0:0]  evt_value;
    logic [4:0]  evt_count;
    logic [15:0] drop_count;

    logic        rst4 = 1'b1;
    logic [0:0]  soi4 = 1'b0;
    logic        en4 = 1'b0;
    logic        ready4 = 1'b0;
    logic        valid4;
    logic [3:0]  ts4;
    logic [0:0]  value4;
    logic [4:0]  count4;
    logic [15:0] drop4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    soi_event_capture dut (
        .clk        (clk),
        .rst        (rst),
        .soi        (soi),
        .enable     (enable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ts     (evt_ts),
        .evt_value  (evt_value),
        .evt_count  (evt_count),
        .drop_count (drop_count)
    );

    soi_event_capture #(.TS_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .soi        (soi4),
        .enable     (en4),
        .evt_valid  (valid4),
        .evt_ready  (ready4),
        .evt_ts     (ts4),
        .evt_value  (value4),
        .evt_count  (count4),
        .drop_count (drop4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        // Reset state
        do_reset();
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", evt_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ts", evt_ts, 0);
        chk("rst_value", evt_value, 0);

        // Steady soi: nothing captured
        enable = 1'b1; soi = 1'b0;
        tick(10);
        chk("idle_valid", evt_valid, 0);
        chk("idle_drop", drop_count, 0);

        // Arm at ts=3, change sampled at ts=7
        do_reset();
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(4);
        soi = 1'b1;
        tick();
        chk("single_valid", evt_valid, 1);
        chk("single_ts", evt_ts, 7);
        chk("single_value", evt_value, 1);
        chk("single_count", evt_count, 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("single_pop_count", evt_count, 0);
        chk("single_pop_valid", evt_valid, 0);

        // 20 changes into a 16-deep queue, edges ts=9..28
        for (int i = 0; i < 20; i++) begin
            soi = ~soi;
            tick();
        end
        chk("over_count", evt_count, 16);
        chk("over_drop", drop_count, 4);
        evt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", evt_valid, 1);
            chk("drain_ts", evt_ts, 64'(9 + i));
            chk("drain_value", evt_value, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
        end
        evt_ready = 1'b0;
        chk("drain_count", evt_count, 0);
        chk("drain_drop", drop_count, 4);

        // Refill at ts=45..60, then 5 edges of simultaneous push+pop
        for (int i = 0; i < 16; i++) begin
            soi = ~soi;
            tick();
        end
        chk("full_count", evt_count, 16);
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            soi = ~soi;
            tick();
            chk("pushpop_count", evt_count, 16);
            chk("pushpop_drop", drop_count, 4);
        end
        chk("pushpop_head_ts", evt_ts, 50);
        chk("pushpop_head_value", evt_value, 1);
        tick(16);
        evt_ready = 1'b0;
        chk("pushpop_drained", evt_count, 0);

        // Disable, change, re-enable: no spurious event
        do_reset();
        enable = 1'b1; soi = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        soi = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        chk("rearm_valid", evt_valid, 0);
        chk("rearm_count", evt_count, 0);
        soi = 1'b0;
        tick();
        chk("rearm_evt_valid", evt_valid, 1);
        chk("rearm_evt_value", evt_value, 0);

        // Reset mid-operation with 5 queued and 2 dropped
        for (int i = 0; i < 17; i++) begin
            soi = ~soi;
            tick();
        end
        chk("pre_rst_count16", evt_count, 16);
        chk("pre_rst_drop", drop_count, 2);
        evt_ready = 1'b1;
        tick(11);
        evt_ready = 1'b0;
        chk("pre_rst_count5", evt_count, 5);
        do_reset();
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_count", evt_count, 0);
        chk("mid_rst_drop", drop_count, 0);
        soi = 1'b0;
        tick();
        soi = 1'b1;
        tick();
        chk("post_rst_ts", evt_ts, 1);
        chk("post_rst_value", evt_value, 1);

        // Timestamp wrap on the 4-bit instance
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        en4 = 1'b1; soi4 = 1'b0;
        tick(15);
        soi4 = 1'b1;
        tick();
        tick();
        soi4 = 1'b0;
        tick();
        chk("wrap_count", count4, 2);
        chk("wrap_ts0", ts4, 15);
        chk("wrap_value0", value4, 1);
        ready4 = 1'b1;
        tick();
        ready4 = 1'b0;
        chk("wrap_ts1", ts4, 1);
        chk("wrap_value1", value4, 0);
        chk("wrap_drop", drop4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
